// File: rtl/credit_arb_pkg.sv
// Shared types and helpers for the credit bidding arbiter.
package credit_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotating first-set scan over the low n bits of vec, starting at index start.
  // Returns {found, index}.
  function automatic logic [4:0] rot_first(input logic [15:0] vec,
                                           input int unsigned start,
                                           input int unsigned n);
    logic [4:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = (start + k) % n;
      if (k < n && !res[4] && vec[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/credit_bank.sv
// Per-requester credit balance: deduct with floor 0, then saturating refill.
module credit_bank #(
  parameter int unsigned BID_W      = 4,
  parameter int unsigned BAL_W      = 10,
  parameter int unsigned INIT_BAL   = 64,
  parameter int unsigned REFILL_AMT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             deduct_en,
  input  logic [BID_W-1:0] deduct_amt,
  input  logic             refill_tick,
  output logic [BAL_W-1:0] balance
);

  localparam int unsigned SUM_W = BAL_W + 1;
  localparam logic [SUM_W-1:0] BAL_MAX = SUM_W'((2 ** BAL_W) - 1);

  logic [BAL_W-1:0] amt;
  logic [BAL_W-1:0] after_ded;
  logic [BAL_W-1:0] bal_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    amt       = BAL_W'(deduct_amt);
    after_ded = balance;
    if (deduct_en) after_ded = (amt >= balance) ? '0 : balance - amt;
    sum   = {1'b0, after_ded} + SUM_W'(REFILL_AMT);
    bal_d = after_ded;
    if (refill_tick) bal_d = (sum > BAL_MAX) ? BAL_MAX[BAL_W-1:0] : sum[BAL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) balance <= BAL_W'(INIT_BAL);
    else     balance <= bal_d;
  end

endmodule

// File: rtl/credit_bid_arbiter.sv
// N-requester credit bidding arbiter with starvation override, round-robin
// tie-break and a registered one-hot grant held until done.
module credit_bid_arbiter
  import credit_arb_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned BID_W         = 4,
  parameter int unsigned BAL_W         = 10,
  parameter int unsigned INIT_BAL      = 64,
  parameter int unsigned REFILL_AMT    = 1,
  parameter int unsigned REFILL_PERIOD = 16,
  parameter int unsigned STARVE_TH     = 32,
  parameter int unsigned CNT_W         = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*BID_W-1:0]     bid,
  input  logic                   done,
  output logic [N-1:0]           grant,
  output logic [$clog2(N)-1:0]   grant_idx,
  output logic [N*BAL_W-1:0]     balance
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned RP_W  = $clog2(REFILL_PERIOD + 1);

  state_t             state_q, state_d;
  logic [N-1:0]       grant_d;
  logic [IDX_W-1:0]   grant_idx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [N-1:0]       deduct_en;

  logic [BID_W-1:0]   bid_a  [N];
  logic [BAL_W-1:0]   bal_a  [N];
  logic [CNT_W-1:0]   wait_q [N];

  logic [RP_W-1:0]    refill_cnt;
  logic               refill_tick;

  logic [N-1:0]       bid_v, starved, eligible, top_mask;
  logic [BID_W-1:0]   max_bid;
  int unsigned        start;
  logic [4:0]         pick;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_req
    assign bid_a[gi] = bid[gi*BID_W +: BID_W];
    assign balance[gi*BAL_W +: BAL_W] = bal_a[gi];

    credit_bank #(
      .BID_W     (BID_W),
      .BAL_W     (BAL_W),
      .INIT_BAL  (INIT_BAL),
      .REFILL_AMT(REFILL_AMT)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .deduct_en  (deduct_en[gi]),
      .deduct_amt (bid_a[gi]),
      .refill_tick(refill_tick),
      .balance    (bal_a[gi])
    );
  end

  // Winner selection: starved, then sole bidder, then highest eligible bid.
  always_comb begin
    bid_v    = '0;
    starved  = '0;
    eligible = '0;
    top_mask = '0;
    max_bid  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bid_v[i]    = (bid_a[i] != '0);
      starved[i]  = bid_v[i] && (32'(wait_q[i]) >= STARVE_TH);
      eligible[i] = bid_v[i] && (32'(bal_a[i]) >= 32'(bid_a[i]));
      if (eligible[i] && bid_a[i] > max_bid) max_bid = bid_a[i];
    end
    for (int unsigned i = 0; i < N; i++) begin
      top_mask[i] = eligible[i] && (bid_a[i] == max_bid);
    end
    start = (32'(rr_q) + 32'd1) % N;
    if (|starved)                    pick = rot_first(16'(starved), start, N);
    else if ($countones(bid_v) == 1) pick = rot_first(16'(bid_v), start, N);
    else if (|eligible)              pick = rot_first(16'(top_mask), start, N);
    else                             pick = '0;
    win_found = pick[4];
    win_idx   = IDX_W'(pick[3:0]);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    grant_idx_d = grant_idx;
    rr_d        = rr_q;
    deduct_en   = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          state_d     = GRANT;
          grant_d     = N'(1) << win_idx;
          grant_idx_d = win_idx;
          rr_d        = win_idx;
          deduct_en   = N'(1) << win_idx;
        end
      end
      GRANT: begin
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_q      <= IDX_W'(N - 1);
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      grant_idx <= grant_idx_d;
      rr_q      <= rr_d;
    end
  end

  // Wait counters: count while bidding and not holding the grant.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (rst || !bid_v[i] || grant[i]) wait_q[i] <= '0;
      else if (wait_q[i] != '1)         wait_q[i] <= wait_q[i] + CNT_W'(1);
    end
  end

  assign refill_tick = (refill_cnt == RP_W'(REFILL_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || refill_tick) refill_cnt <= '0;
    else                    refill_cnt <= refill_cnt + RP_W'(1);
  end

endmodule

// File: tb/tb_credit_bid_arbiter.sv
// Scenario bench for credit_bid_arbiter with a cycle-level expectation queue.
module tb_credit_bid_arbiter;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] bid  = '0;
  logic        done = 1'b0;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic [39:0] balance;

  logic        rst_b  = 1'b1;
  logic [15:0] bid_b  = '0;
  logic        done_b = 1'b0;
  logic [3:0]  grant_b;
  logic [1:0]  grant_idx_b;
  logic [39:0] balance_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  credit_bid_arbiter u_dut (
    .clk(clk), .rst(rst), .bid(bid), .done(done),
    .grant(grant), .grant_idx(grant_idx), .balance(balance)
  );

  credit_bid_arbiter #(.INIT_BAL(1023)) u_dut_rich (
    .clk(clk), .rst(rst_b), .bid(bid_b), .done(done_b),
    .grant(grant_b), .grant_idx(grant_idx_b), .balance(balance_b)
  );

  typedef struct packed {
    logic [3:0]  g;
    logic [1:0]  idx;
    logic [39:0] bal;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  // Reference model state for u_dut.
  int       m_st, m_idx, m_rr, m_rc;
  logic [3:0] m_g;
  int       m_bal [4];
  int       m_wait[4];

  initial forever begin
    int   bv[4];
    int   w, mx, nb, j;
    logic found, tick;
    logic [3:0] old_g;
    exp_t x;
    @(posedge clk);
    for (int i = 0; i < 4; i++) bv[i] = int'(bid[i*4 +: 4]);
    if (rst) begin
      m_st = 0; m_g = '0; m_idx = 0; m_rr = 3; m_rc = 0;
      for (int i = 0; i < 4; i++) begin m_bal[i] = 64; m_wait[i] = 0; end
    end else begin
      old_g = m_g;
      tick  = (m_rc == 15);
      m_rc  = tick ? 0 : m_rc + 1;
      if (m_st == 0) begin
        found = 1'b0; w = 0;
        for (int k = 1; k <= 4; k++) begin
          j = (m_rr + k) % 4;
          if (!found && bv[j] != 0 && m_wait[j] >= 32) begin found = 1'b1; w = j; end
        end
        if (!found) begin
          nb = 0;
          for (int i = 0; i < 4; i++) if (bv[i] != 0) begin nb++; w = i; end
          if (nb == 1) found = 1'b1;
        end
        if (!found) begin
          mx = 0;
          for (int i = 0; i < 4; i++)
            if (bv[i] != 0 && m_bal[i] >= bv[i] && bv[i] > mx) mx = bv[i];
          for (int k = 1; k <= 4; k++) begin
            j = (m_rr + k) % 4;
            if (!found && mx > 0 && bv[j] == mx && m_bal[j] >= mx) begin found = 1'b1; w = j; end
          end
        end
        if (found) begin
          m_g = 4'b0001 << w; m_idx = w; m_rr = w; m_st = 1;
          m_bal[w] = (m_bal[w] > bv[w]) ? m_bal[w] - bv[w] : 0;
        end else begin
          m_g = '0;
        end
      end else if (done) begin
        m_g = '0; m_st = 0;
      end
      if (tick) for (int i = 0; i < 4; i++) m_bal[i] = (m_bal[i] < 1023) ? m_bal[i] + 1 : 1023;
      for (int i = 0; i < 4; i++) begin
        if (bv[i] == 0 || old_g[i]) m_wait[i] = 0;
        else if (m_wait[i] < 63)    m_wait[i] = m_wait[i] + 1;
      end
    end
    x.g = m_g; x.idx = 2'(m_idx);
    for (int i = 0; i < 4; i++) x.bal[i*10 +: 10] = 10'(m_bal[i]);
    sb_q.push_back(x);
  end

  // Compare DUT outputs against the queued expectation, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (grant !== e.g) begin
        errors++; $display("FAIL sb_grant t=%0t got=%b exp=%b", $time, grant, e.g);
      end
      checks++;
      if (grant_idx !== e.idx) begin
        errors++; $display("FAIL sb_grant_idx t=%0t got=%0d exp=%0d", $time, grant_idx, e.idx);
      end
      checks++;
      if (balance !== e.bal) begin
        errors++; $display("FAIL sb_balance t=%0t got=%h exp=%h", $time, balance, e.bal);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; done = 1'b0; bid = 16'($urandom);
    cycle(); cycle();
    rst = 1'b0; bid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bid = 16'($urandom);
    cycle(); cycle();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++;
    if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
    checks++;
    if (balance !== {4{10'd64}}) begin errors++; $display("FAIL reset_balance got=%h exp=%h", balance, {4{10'd64}}); end
    rst = 1'b0; bid = '0;
    cycle();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_nobid_grant got=%b exp=0000", grant); end
  endtask

  task automatic test_highest_bid();
    apply_reset();
    bid = {4'd2, 4'd9, 4'd5, 4'd1};
    cycle();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL high_grant got=%b exp=0100", grant); end
    checks++;
    if (grant_idx !== 2'd2) begin errors++; $display("FAIL high_idx got=%0d exp=2", grant_idx); end
    checks++;
    if (balance !== {10'd64, 10'd55, 10'd64, 10'd64}) begin
      errors++; $display("FAIL high_balance got=%h exp=%h", balance, {10'd64, 10'd55, 10'd64, 10'd64});
    end
    bid = '0; done = 1'b1;
    cycle();
    done = 1'b0;
  endtask

  task automatic test_tie_rr();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0001;
    apply_reset();
    bid = {8'd0, 4'd7, 4'd7};
    for (int r = 0; r < 3; r++) begin
      cycle();
      checks++;
      if (grant !== exp_g[r]) begin errors++; $display("FAIL tie_grant_%0d got=%b exp=%b", r, grant, exp_g[r]); end
      done = 1'b1;
      cycle();
      checks++;
      if (grant !== 4'b0000) begin errors++; $display("FAIL tie_bubble_%0d got=%b exp=0000", r, grant); end
      done = 1'b0;
    end
    bid = '0;
    cycle();
  endtask

  task automatic test_sole_floor();
    int drain[5];
    drain = '{15, 15, 15, 15, 1};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      bid = 16'(drain[k] << 4);
      cycle();
      done = 1'b1;
      cycle();
      done = 1'b0;
    end
    checks++;
    if (balance[19:10] !== 10'd3) begin errors++; $display("FAIL sole_drain got=%0d exp=3", balance[19:10]); end
    bid = {8'd0, 4'd15, 4'd0};
    cycle();
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL sole_grant got=%b exp=0010", grant); end
    checks++;
    if (balance[19:10] !== 10'd0) begin errors++; $display("FAIL sole_floor got=%0d exp=0", balance[19:10]); end
    done = 1'b1;
    cycle();
    done = 1'b0;
    bid = {8'd0, 4'd15, 4'd1};
    cycle();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL broke_bidder_grant got=%b exp=0001", grant); end
    bid = '0; done = 1'b1;
    cycle();
    done = 1'b0;
  endtask

  task automatic test_starvation();
    int seq[$];
    int exp_i;
    rst_b = 1'b1; bid_b = '0; done_b = 1'b0;
    cycle(); cycle();
    rst_b = 1'b0; bid_b = {8'd0, 4'd15, 4'd2}; done_b = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (grant_b != 4'b0000) seq.push_back(int'(grant_idx_b));
    end
    checks++;
    if (seq.size() < 18) begin
      errors++; $display("FAIL starve_grant_count got=%0d exp>=18", seq.size());
    end else begin
      for (int k = 0; k < 18; k++) begin
        exp_i = (k == 16) ? 0 : 1;
        checks++;
        if (seq[k] !== exp_i) begin errors++; $display("FAIL starve_seq_%0d got=%0d exp=%0d", k, seq[k], exp_i); end
      end
    end
    bid_b = '0; done_b = 1'b0; rst_b = 1'b1;
  endtask

  task automatic test_refill_reset_mid_grant();
    apply_reset();
    for (int c = 0; c < 15500; c++) cycle();
    checks++;
    if (balance !== {4{10'd1023}}) begin errors++; $display("FAIL refill_sat got=%h exp=%h", balance, {4{10'd1023}}); end
    for (int c = 0; c < 40; c++) cycle();
    checks++;
    if (balance !== {4{10'd1023}}) begin errors++; $display("FAIL refill_hold got=%h exp=%h", balance, {4{10'd1023}}); end
    bid = {4'd15, 12'd0};
    cycle();
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL rich_grant got=%b exp=1000", grant); end
    rst = 1'b1;
    cycle();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant got=%b exp=0000", grant); end
    checks++;
    if (grant_idx !== 2'd0) begin errors++; $display("FAIL midrst_idx got=%0d exp=0", grant_idx); end
    checks++;
    if (balance !== {4{10'd64}}) begin errors++; $display("FAIL midrst_balance got=%h exp=%h", balance, {4{10'd64}}); end
    rst = 1'b0; bid = '0;
    cycle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_highest_bid();
    test_tie_rr();
    test_sole_floor();
    test_starvation();
    test_refill_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
